// File: rtl/pc_sequencer.sv
// Next-PC controller: arbitrates sequential advance, branch, trap entry and trap return,
// and runs the BOOT/RUN/HANDLER/HALT trap machine. Define PC_SEQUENCER_INSTRET_EN for instretCount.
module pc_sequencer #(
  parameter logic [31:0] INITIAL_PC  = 32'h00000000,
  parameter logic [31:0] TRAP_VECTOR = 32'h00000004
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] pcOfInstruction,
  input  logic        programCounterMisaligned,
  output logic [31:0] programCounterInput,
  output logic        programCounterWriteEnable,
  input  logic        stall,
  input  logic        advance,
  input  logic        branchTaken,
  input  logic [31:0] branchTarget,
  input  logic        trapRequest,
  input  logic        trapReturn,
  output logic [31:0] savedPc,
  output logic [1:0]  trapCause,
  output logic        inTrap,
  output logic        halted,
  output logic [63:0] instretCount
);

  typedef enum logic [1:0] {StBoot, StRun, StHandler, StHalt} state_e;

  state_e      state_q, state_d;
  logic [31:0] saved_pc_q, saved_pc_d;
  logic [1:0]  trap_cause_q, trap_cause_d;
  logic        fault;
  logic        retire;
  logic [31:0] pc_plus4;
  logic [31:0] saved_plus4;

  // Misalignment outranks an explicit trap request; both are faults in HANDLER.
  assign fault       = programCounterMisaligned | trapRequest;
  assign pc_plus4    = pcOfInstruction + 32'd4;
  assign saved_plus4 = saved_pc_q + 32'd4;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q      <= StBoot;
      saved_pc_q   <= '0;
      trap_cause_q <= '0;
    end else begin
      state_q      <= state_d;
      saved_pc_q   <= saved_pc_d;
      trap_cause_q <= trap_cause_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    saved_pc_d   = saved_pc_q;
    trap_cause_d = trap_cause_q;
    retire       = 1'b0;
    unique case (state_q)
      StBoot: state_d = StRun;
      StRun: begin
        if (!stall) begin
          if (fault) begin
            state_d      = StHandler;
            saved_pc_d   = pcOfInstruction;
            trap_cause_d = programCounterMisaligned ? 2'd0 : 2'd1;
          end else begin
            retire = advance;
          end
        end
      end
      StHandler: begin
        if (!stall) begin
          if (fault) begin
            state_d = StHalt;
          end else if (advance) begin
            retire = 1'b1;
            if (trapReturn) state_d = StRun;
          end
        end
      end
      default: state_d = StHalt;
    endcase
  end

  always_comb begin
    programCounterWriteEnable = 1'b0;
    programCounterInput       = pc_plus4;
    unique case (state_q)
      StBoot: begin
        programCounterWriteEnable = 1'b1;
        programCounterInput       = INITIAL_PC;
      end
      StRun, StHandler: begin
        if (!stall) begin
          if (fault) begin
            // A fault in HANDLER is a double fault: the PC is left untouched.
            if (state_q == StRun) begin
              programCounterWriteEnable = 1'b1;
              programCounterInput       = TRAP_VECTOR;
            end
          end else if (advance) begin
            programCounterWriteEnable = 1'b1;
            if (state_q == StHandler && trapReturn) begin
              programCounterInput = saved_plus4;
            end else if (branchTaken) begin
              programCounterInput = branchTarget;
            end else begin
              programCounterInput = pc_plus4;
            end
          end
        end
      end
      default: ;
    endcase
  end

  assign savedPc   = saved_pc_q;
  assign trapCause = trap_cause_q;
  assign inTrap    = (state_q == StHandler);
  assign halted    = (state_q == StHalt);

`ifdef PC_SEQUENCER_INSTRET_EN
  logic [63:0] instret_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      instret_q <= '0;
    end else if (retire) begin
      instret_q <= instret_q + 64'd1;
    end
  end

  assign instretCount = instret_q;
`else
  logic unused_retire;
  assign unused_retire = retire;
  assign instretCount  = 64'd0;
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: bench-owned PC register, behavioural model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_pc_sequencer;

  localparam logic [31:0] InitPc  = 32'h00000100;
  localparam logic [31:0] TrapVec = 32'h00000004;
  localparam logic [1:0] ModeBoot = 2'd0, ModeRun = 2'd1, ModeHandler = 2'd2, ModeHalt = 2'd3;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] pc_q;
  logic        misaligned;
  logic [31:0] pc_in;
  logic        pc_we;
  logic        stall = 1'b0, advance = 1'b0, branchTaken = 1'b0;
  logic        trapRequest = 1'b0, trapReturn = 1'b0;
  logic [31:0] branchTarget = 32'h0;
  logic [31:0] savedPc;
  logic [1:0]  trapCause;
  logic        inTrap, halted;
  logic [63:0] instretCount;

  int checks = 0;
  int passes = 0;

  always #5 clock = ~clock;

  pc_sequencer #(
    .INITIAL_PC (InitPc),
    .TRAP_VECTOR(TrapVec)
  ) dut (
    .clock                    (clock),
    .reset                    (reset),
    .pcOfInstruction          (pc_q),
    .programCounterMisaligned (misaligned),
    .programCounterInput      (pc_in),
    .programCounterWriteEnable(pc_we),
    .stall                    (stall),
    .advance                  (advance),
    .branchTaken              (branchTaken),
    .branchTarget             (branchTarget),
    .trapRequest              (trapRequest),
    .trapReturn               (trapReturn),
    .savedPc                  (savedPc),
    .trapCause                (trapCause),
    .inTrap                   (inTrap),
    .halted                   (halted),
    .instretCount             (instretCount)
  );

  // The program counter register the sequencer writes.
  assign misaligned = (pc_q[1:0] != 2'b00);
  always @(posedge clock or negedge reset) begin
    if (!reset) pc_q <= 32'h0;
    else if (pc_we) pc_q <= pc_in;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) $display("FAIL %s: got %h, expected %h", name, act, exp);
    else passes++;
  endtask

  // Behavioural model: mode, saved PC, cause and retired count.
  logic [1:0]  m_mode;
  logic [31:0] m_saved;
  logic [1:0]  m_cause;
  logic [63:0] m_inst;
  logic        exp_we;
  logic [31:0] exp_data;
  logic [1:0]  exp_mode;
  logic [31:0] exp_saved;
  logic [1:0]  exp_cause;
  logic [63:0] exp_inst;

  always_comb begin
    exp_we    = 1'b0;
    exp_data  = pc_q + 32'd4;
    exp_mode  = m_mode;
    exp_saved = m_saved;
    exp_cause = m_cause;
    exp_inst  = m_inst;
    if (m_mode == ModeBoot) begin
      exp_we   = 1'b1;
      exp_data = InitPc;
      exp_mode = ModeRun;
    end else if (m_mode == ModeHalt || stall) begin
    end else if (misaligned || trapRequest) begin
      if (m_mode == ModeRun) begin
        exp_we    = 1'b1;
        exp_data  = TrapVec;
        exp_saved = pc_q;
        exp_cause = misaligned ? 2'd0 : 2'd1;
        exp_mode  = ModeHandler;
      end else begin
        exp_mode = ModeHalt;
      end
    end else if (advance) begin
      exp_we   = 1'b1;
      exp_inst = m_inst + 64'd1;
      if (m_mode == ModeHandler && trapReturn) begin
        exp_data = m_saved + 32'd4;
        exp_mode = ModeRun;
      end else if (branchTaken) begin
        exp_data = branchTarget;
      end
    end
  end

  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      m_mode  <= ModeBoot;
      m_saved <= 32'h0;
      m_cause <= 2'd0;
      m_inst  <= 64'd0;
    end else begin
      m_mode  <= exp_mode;
      m_saved <= exp_saved;
      m_cause <= exp_cause;
      m_inst  <= exp_inst;
    end
  end

  always @(negedge clock) begin
    if (reset) begin
      chk("cyc_we", {63'd0, pc_we}, {63'd0, exp_we});
      chk("cyc_data", {32'd0, pc_in}, {32'd0, exp_data});
      chk("cyc_saved", {32'd0, savedPc}, {32'd0, m_saved});
      chk("cyc_cause", {62'd0, trapCause}, {62'd0, m_cause});
      chk("cyc_intrap", {63'd0, inTrap}, {63'd0, (m_mode == ModeHandler)});
      chk("cyc_halted", {63'd0, halted}, {63'd0, (m_mode == ModeHalt)});
`ifdef PC_SEQUENCER_INSTRET_EN
      chk("cyc_instret", instretCount, m_inst);
`else
      chk("cyc_instret", instretCount, 64'd0);
`endif
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic adv, input logic br, input logic [31:0] tgt,
                       input logic trq, input logic tret, input logic stl);
    advance      = adv;
    branchTaken  = br;
    branchTarget = tgt;
    trapRequest  = trq;
    trapReturn   = tret;
    stall        = stl;
  endtask

  initial begin
    logic [63:0] inst0;
    logic [31:0] tgt;
    drive(0, 0, 0, 0, 0, 0);
    repeat (3) @(posedge clock);
    #3;
    chk("rst_saved", {32'd0, savedPc}, 64'd0);
    chk("rst_cause", {62'd0, trapCause}, 64'd0);
    chk("rst_intrap", {63'd0, inTrap}, 64'd0);
    chk("rst_halted", {63'd0, halted}, 64'd0);
    @(posedge clock);
    #1 reset = 1'b1;
    #2;
    chk("boot_we", {63'd0, pc_we}, 64'd1);
    chk("boot_data", {32'd0, pc_in}, {32'd0, InitPc});
    tick();
    chk("boot_pc", {32'd0, pc_q}, 64'h100);
    drive(1, 0, 0, 0, 0, 0);
    tick(); chk("adv_pc1", {32'd0, pc_q}, 64'h104);
    tick(); chk("adv_pc2", {32'd0, pc_q}, 64'h108);
    tick(); chk("adv_pc3", {32'd0, pc_q}, 64'h10C);

    // Trap request at 0x400, then trap return from HANDLER and the same inputs in RUN.
    drive(1, 1, 32'h400, 0, 0, 0);
    tick(); chk("br_pc400", {32'd0, pc_q}, 64'h400);
    drive(0, 0, 0, 1, 0, 0);
    tick();
    chk("trq_saved", {32'd0, savedPc}, 64'h400);
    chk("trq_cause", {62'd0, trapCause}, 64'd1);
    chk("trq_pc", {32'd0, pc_q}, {32'd0, TrapVec});
    drive(1, 0, 0, 0, 1, 0);
    tick();
    chk("ret_pc", {32'd0, pc_q}, 64'h404);
    chk("ret_intrap", {63'd0, inTrap}, 64'd0);
    tick();
    chk("ret_run_pc", {32'd0, pc_q}, 64'h408);
    chk("ret_run_saved", {32'd0, savedPc}, 64'h400);

    // Misaligned branch target traps on the following cycle.
    drive(1, 1, 32'h200, 0, 0, 0);
    tick(); chk("br_pc200", {32'd0, pc_q}, 64'h200);
    drive(1, 1, 32'h302, 0, 0, 0);
    tick(); chk("br_pc302", {32'd0, pc_q}, 64'h302);
    drive(0, 0, 0, 0, 0, 0);
    #2;
    chk("mis_we", {63'd0, pc_we}, 64'd1);
    chk("mis_data", {32'd0, pc_in}, {32'd0, TrapVec});
    tick();
    chk("mis_saved", {32'd0, savedPc}, 64'h302);
    chk("mis_cause", {62'd0, trapCause}, 64'd0);
    chk("mis_pc", {32'd0, pc_q}, {32'd0, TrapVec});
    chk("mis_intrap", {63'd0, inTrap}, 64'd1);

    // Double fault halts; only reset recovers.
    drive(0, 0, 0, 1, 0, 0);
    tick();
    chk("dbl_halted", {63'd0, halted}, 64'd1);
    chk("dbl_saved", {32'd0, savedPc}, 64'h302);
    drive(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 10; i++) begin
      #2;
      chk("halt_we", {63'd0, pc_we}, 64'd0);
      tick();
    end
    chk("halt_pc", {32'd0, pc_q}, {32'd0, TrapVec});
    reset = 1'b0;
    #2;
    chk("rst2_halted", {63'd0, halted}, 64'd0);
    tick();
    reset = 1'b1;
    drive(0, 0, 0, 0, 0, 0);
    #2;
    chk("rst2_we", {63'd0, pc_we}, 64'd1);
    chk("rst2_data", {32'd0, pc_in}, {32'd0, InitPc});
    tick();
    chk("rst2_pc", {32'd0, pc_q}, {32'd0, InitPc});

    // Stall holds a pending trap request until release.
    drive(1, 0, 0, 1, 0, 1);
    for (int i = 0; i < 4; i++) begin
      #2;
      chk("stall_we", {63'd0, pc_we}, 64'd0);
      tick();
      chk("stall_pc", {32'd0, pc_q}, 64'h100);
    end
    drive(1, 0, 0, 1, 0, 0);
    tick();
    chk("unstall_cause", {62'd0, trapCause}, 64'd1);
    chk("unstall_saved", {32'd0, savedPc}, 64'h100);
    chk("unstall_pc", {32'd0, pc_q}, {32'd0, TrapVec});
    drive(1, 0, 0, 0, 1, 0);
    tick();
    chk("unstall_ret_pc", {32'd0, pc_q}, 64'h104);

    // 32-bit wrap of the sequential increment.
    drive(1, 1, 32'hFFFFFFFC, 0, 0, 0);
    tick();
    chk("wrap_pre", {32'd0, pc_q}, 64'hFFFFFFFC);
    inst0 = instretCount;
    drive(1, 0, 0, 0, 0, 0);
    tick();
    chk("wrap_pc", {32'd0, pc_q}, 64'd0);
`ifdef PC_SEQUENCER_INSTRET_EN
    chk("wrap_instret", instretCount, inst0 + 64'd1);
`else
    chk("wrap_instret", instretCount, 64'd0);
`endif

    // Randomized traffic, checked every cycle by the model.
    for (int i = 0; i < 3000; i++) begin
      if ((m_mode == ModeHalt && $urandom_range(3) == 0) || $urandom_range(299) == 0) begin
        reset = 1'b0;
        tick();
        reset = 1'b1;
      end
      tgt = $urandom;
      if ($urandom_range(9) != 0) tgt[1:0] = 2'b00;
      drive($urandom_range(3) != 0, $urandom_range(3) == 0, tgt,
            $urandom_range(15) == 0, $urandom_range(2) == 0, $urandom_range(7) == 0);
      tick();
    end

    drive(0, 0, 0, 0, 0, 0);
    tick();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
